// File: rtl/vrf_pkg.sv
// Shared definitions for the vector register file: default geometry and FSM states.
package vrf_pkg;

  localparam int VRF_VLEN  = 128;
  localparam int VRF_ELEN  = 32;
  localparam int VRF_NREGS = 32;
  localparam int VRF_NELEM = VRF_VLEN / VRF_ELEN;
  localparam int VRF_AW    = $clog2(VRF_NREGS);

  typedef enum logic {
    VRF_INIT,
    VRF_RUN
  } vrf_state_e;

endpackage

// File: rtl/vrf_read_port.sv
// One registered read port: selects a register, optionally merges a same-cycle
// masked write into it, and holds zero while the file is not yet initialised.
module vrf_read_port import vrf_pkg::*; #(
  parameter int VLEN   = VRF_VLEN,
  parameter int ELEN   = VRF_ELEN,
  parameter int NREGS  = VRF_NREGS,
  parameter int BYPASS = 1,
  parameter int NELEM  = VLEN / ELEN,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [AW-1:0]    idx,
  input  logic [VLEN-1:0]  regs [NREGS],
  input  logic             we,
  input  logic [AW-1:0]    vd,
  input  logic [VLEN-1:0]  w_data,
  input  logic [NELEM-1:0] w_mask,
  output logic [VLEN-1:0]  rd_data
);

  function automatic logic [VLEN-1:0] merge_elems(input logic [VLEN-1:0]  old_v,
                                                  input logic [VLEN-1:0]  new_v,
                                                  input logic [NELEM-1:0] mask);
    logic [VLEN-1:0] res;
    res = old_v;
    for (int k = 0; k < NELEM; k++) begin
      if (mask[k]) res[k*ELEN +: ELEN] = new_v[k*ELEN +: ELEN];
    end
    return res;
  endfunction

  logic [VLEN-1:0] stored;
  logic [VLEN-1:0] merged;

  assign stored = regs[idx];

  always_comb begin
    merged = stored;
    if ((BYPASS != 0) && we && (vd == idx)) merged = merge_elems(stored, w_data, w_mask);
  end

  // Output register: async clear, forced to zero during the init sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rd_data <= '0;
    else if (!run) rd_data <= '0;
    else           rd_data <= merged;
  end

endmodule

// File: rtl/v_reg_file.sv
// Vector register file: NREGS x VLEN storage cleared by a post-reset sweep,
// three registered read ports, a v0 mask port and one element-masked write port.
module v_reg_file import vrf_pkg::*; #(
  parameter int VLEN   = VRF_VLEN,
  parameter int ELEN   = VRF_ELEN,
  parameter int NREGS  = VRF_NREGS,
  parameter int BYPASS = 1,
  parameter int NELEM  = VLEN / ELEN,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ready,
  input  logic             we,
  input  logic [AW-1:0]    vd,
  input  logic [VLEN-1:0]  w_data,
  input  logic [NELEM-1:0] w_mask,
  input  logic [AW-1:0]    vs1,
  input  logic [AW-1:0]    vs2,
  input  logic [AW-1:0]    vs3,
  output logic [VLEN-1:0]  vs1_data,
  output logic [VLEN-1:0]  vs2_data,
  output logic [VLEN-1:0]  vs3_data,
  output logic [VLEN-1:0]  v0_data
);

  vrf_state_e      state, state_nxt;
  logic [AW-1:0]   clr_idx, clr_idx_nxt;
  logic [VLEN-1:0] mem [NREGS];
  logic            we_run;
  logic [AW-1:0]   v0_idx;

  assign ready  = (state == VRF_RUN);
  assign we_run = we && ready;
  assign v0_idx = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= VRF_INIT;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    case (state)
      VRF_INIT: begin
        clr_idx_nxt = clr_idx + 1'b1;
        if (clr_idx == AW'(NREGS - 1)) state_nxt = VRF_RUN;
      end
      default: state_nxt = VRF_RUN;
    endcase
  end

  // Storage has no reset; the sweep zeroes one register per cycle instead.
  always_ff @(posedge clk) begin
    if (state == VRF_INIT) begin
      mem[clr_idx] <= '0;
    end else if (we_run) begin
      for (int k = 0; k < NELEM; k++) begin
        if (w_mask[k]) mem[vd][k*ELEN +: ELEN] <= w_data[k*ELEN +: ELEN];
      end
    end
  end

  vrf_read_port #(.VLEN(VLEN), .ELEN(ELEN), .NREGS(NREGS), .BYPASS(BYPASS)) u_rp_vs1 (
    .clk(clk), .rst_n(rst_n), .run(ready), .idx(vs1), .regs(mem),
    .we(we_run), .vd(vd), .w_data(w_data), .w_mask(w_mask), .rd_data(vs1_data));

  vrf_read_port #(.VLEN(VLEN), .ELEN(ELEN), .NREGS(NREGS), .BYPASS(BYPASS)) u_rp_vs2 (
    .clk(clk), .rst_n(rst_n), .run(ready), .idx(vs2), .regs(mem),
    .we(we_run), .vd(vd), .w_data(w_data), .w_mask(w_mask), .rd_data(vs2_data));

  vrf_read_port #(.VLEN(VLEN), .ELEN(ELEN), .NREGS(NREGS), .BYPASS(BYPASS)) u_rp_vs3 (
    .clk(clk), .rst_n(rst_n), .run(ready), .idx(vs3), .regs(mem),
    .we(we_run), .vd(vd), .w_data(w_data), .w_mask(w_mask), .rd_data(vs3_data));

  vrf_read_port #(.VLEN(VLEN), .ELEN(ELEN), .NREGS(NREGS), .BYPASS(BYPASS)) u_rp_v0 (
    .clk(clk), .rst_n(rst_n), .run(ready), .idx(v0_idx), .regs(mem),
    .we(we_run), .vd(vd), .w_data(w_data), .w_mask(w_mask), .rd_data(v0_data));

endmodule

// File: tb/tb_v_reg_file.sv
// Directed bench for v_reg_file: a write-first and a read-first instance share stimulus.
module tb_v_reg_file;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         we;
  logic [4:0]   vd, vs1, vs2, vs3;
  logic [127:0] w_data;
  logic [3:0]   w_mask;

  logic         rdy1, rdy0;
  logic [127:0] a1, b1, c1, z1;
  logic [127:0] a0, b0, c0, z0;

  int n_vec  = 0;
  int n_miss = 0;
  int n_edges;

  always #5 clk = ~clk;

  v_reg_file #(.BYPASS(1)) dut_wf (
    .clk(clk), .rst_n(rst_n), .ready(rdy1), .we(we), .vd(vd), .w_data(w_data),
    .w_mask(w_mask), .vs1(vs1), .vs2(vs2), .vs3(vs3),
    .vs1_data(a1), .vs2_data(b1), .vs3_data(c1), .v0_data(z1));

  v_reg_file #(.BYPASS(0)) dut_rf (
    .clk(clk), .rst_n(rst_n), .ready(rdy0), .we(we), .vd(vd), .w_data(w_data),
    .w_mask(w_mask), .vs1(vs1), .vs2(vs2), .vs3(vs3),
    .vs1_data(a0), .vs2_data(b0), .vs3_data(c0), .v0_data(z0));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 0; i < 64 && !rdy1; i++) begin
      step();
      n++;
    end
  endtask

  localparam logic [127:0] PAT_M  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] EXP_M  = 128'hFFFF_FFFF_3333_4444_FFFF_FFFF_7777_8888;
  localparam logic [127:0] PAT_A  = 128'hA5A5_0001_5A5A_0002_C3C3_0003_3C3C_0004;
  localparam logic [127:0] PAT_B  = 128'hDEAD_BEEF_0BAD_F00D_1234_5678_9ABC_DEF0;
  localparam logic [127:0] PAT_C  = 128'hCAFE_0000_BABE_1111_FACE_2222_D00D_3333;
  localparam logic [127:0] V0_DAT = 128'hAAAA_AAAA_BBBB_BBBB_CCCC_CCCC_0000_000F;

  // Three-port burst on reg 9: data, mask and hand-computed register contents after each write.
  logic [127:0] tp_dat [4];
  logic [3:0]   tp_msk [4];
  logic [127:0] tp_exp [4];

  initial begin
    tp_dat[0] = 128'h0101_0101_0202_0202_0303_0303_0404_0404; tp_msk[0] = 4'b1111;
    tp_exp[0] = 128'h0101_0101_0202_0202_0303_0303_0404_0404;
    tp_dat[1] = 128'hEEEE_EEEE_EEEE_EEEE_9999_9999_8888_8888; tp_msk[1] = 4'b0011;
    tp_exp[1] = 128'h0101_0101_0202_0202_9999_9999_8888_8888;
    tp_dat[2] = 128'h7777_7777_6666_6666_5555_5555_4444_4444; tp_msk[2] = 4'b1000;
    tp_exp[2] = 128'h7777_7777_0202_0202_9999_9999_8888_8888;
    tp_dat[3] = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF; tp_msk[3] = 4'b0000;
    tp_exp[3] = 128'h7777_7777_0202_0202_9999_9999_8888_8888;

    rst_n = 1'b0; we = 1'b1; vd = 5'd3; w_data = '1; w_mask = 4'hF;
    vs1 = 5'd31; vs2 = 5'd3; vs3 = 5'd0;
    repeat (3) step();
    chk("rst_ready", {127'd0, rdy1}, 128'd1 - 128'd1);
    chk("rst_vs1", a1, '0);
    chk("rst_v0", z1, '0);

    // Init sweep with we held high: nothing may be written.
    rst_n = 1'b1;
    wait_ready(n_edges);
    chk("init_edges", 128'(n_edges), 128'd32);
    chk("init_ready_rf", {127'd0, rdy0}, 128'd1);
    we = 1'b0;
    step();
    chk("init_r31", a1, '0);
    chk("init_r3_wf", b1, '0);
    chk("init_r3_rf", b0, '0);

    // Element-masked write to reg 5.
    we = 1'b1; vd = 5'd5; w_data = '1; w_mask = 4'b1111;
    step();
    w_data = PAT_M; w_mask = 4'b0101;
    step();
    we = 1'b0; vs1 = 5'd5;
    step();
    chk("mask_wr_wf", a1, EXP_M);
    chk("mask_wr_rf", a0, EXP_M);
    we = 1'b1; w_data = '0; w_mask = 4'b0000;
    step();
    chk("mask_zero_wf", a1, EXP_M);
    we = 1'b0;
    step();
    chk("mask_zero_rf", a0, EXP_M);

    // Same-cycle write/read of reg 7.
    we = 1'b1; vd = 5'd7; w_data = PAT_B; w_mask = 4'hF;
    step();
    w_data = PAT_A; vs2 = 5'd7;
    step();
    chk("byp_wf_same", b1, PAT_A);
    chk("byp_rf_old", b0, PAT_B);
    we = 1'b0;
    step();
    chk("byp_rf_next", b0, PAT_A);
    chk("byp_wf_hold", b1, PAT_A);

    // v0 path against vs3 reading index 0.
    we = 1'b1; vd = 5'd0; w_data = V0_DAT; w_mask = 4'b0001; vs3 = 5'd0;
    step();
    chk("v0_wf", z1, 128'hF);
    chk("v0_vs3_wf", c1, 128'hF);
    chk("v0_rf_old", z0, '0);
    chk("v0_vs3_rf_old", c0, '0);
    we = 1'b0;
    step();
    chk("v0_rf", z0, 128'hF);
    chk("v0_vs3_rf", c0, 128'hF);

    // Three ports on one register during a write burst.
    vs1 = 5'd9; vs2 = 5'd9; vs3 = 5'd9; vd = 5'd9; we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_data = tp_dat[i]; w_mask = tp_msk[i];
      step();
      chk($sformatf("tp%0d_vs1", i), a1, tp_exp[i]);
      chk($sformatf("tp%0d_vs2", i), b1, tp_exp[i]);
      chk($sformatf("tp%0d_vs3", i), c1, tp_exp[i]);
      chk($sformatf("tp%0d_rf", i), b0, (i == 0) ? 128'd0 : tp_exp[(i == 0) ? 0 : i - 1]);
    end

    // Reset in the middle of a write burst.
    vd = 5'd11; w_data = PAT_C; w_mask = 4'hF; vs1 = 5'd11;
    step();
    step();
    chk("burst_pre", a1, PAT_C);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {127'd0, rdy1}, '0);
    chk("mid_rst_vs1", a1, '0);
    chk("mid_rst_v0_wf", z1, '0);
    chk("mid_rst_v0_rf", z0, '0);
    step();
    step();
    rst_n = 1'b1;
    wait_ready(n_edges);
    chk("reinit_edges", 128'(n_edges), 128'd32);
    we = 1'b0; vs1 = 5'd11; vs2 = 5'd5; vs3 = 5'd7;
    step();
    chk("reinit_r11", a1, '0);
    chk("reinit_r5", b1, '0);
    chk("reinit_r7", c1, '0);
    chk("reinit_v0", z1, '0);
    chk("reinit_r11_rf", a0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/v_reg_file.md
# v_reg_file

Vector register file for the RV32V datapath: NREGS architectural vector registers of VLEN bits, three registered read ports, one element-masked write port and a dedicated v0 mask output. It is the parametrised successor of the scalar X register file. It sits between vector decode/operand fetch and the vector ALU/LSU writeback. After reset it clears its storage with a one-register-per-cycle init sweep, so no asynchronous reset is needed on the array.

## Interface
Parameters:
- VLEN, 128: bits per vector register; must be a multiple of ELEN.
- ELEN, 32: element width; write-mask granularity.
- NREGS, 32: number of vector registers; must be a power of two.
- BYPASS, 1: 1 = write-first (a read sees a same-cycle write); 0 = read-first.

Derived: NELEM = VLEN/ELEN; AW = log2(NREGS).

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ready  out  1  high when the init sweep is complete and accesses are accepted.
- we  in  1  write enable. Ignored while ready=0.
- vd  in  AW  write register index.
- w_data  in  VLEN  write data.
- w_mask  in  NELEM  per-element write enable. Bit k covers w_data[k*ELEN +: ELEN].
- vs1, vs2, vs3  in  AW  read indices.
- vs1_data, vs2_data, vs3_data  out  VLEN  registered read data.
- v0_data  out  VLEN  registered copy of register 0, for masked operations.

## Operation
- FSM states: INIT, RUN.
  - INIT: 5-bit (AW) counter clr_idx writes all-zeros to reg[clr_idx] each cycle. When clr_idx = NREGS-1, the write completes and the FSM moves to RUN.
  - RUN: terminal state; left only by reset.
- ready = (state == RUN), registered.
- In RUN, on a clock edge with we=1, element k of reg[vd] takes w_data element k for every k with w_mask[k]=1. Unmasked elements hold their value.
- we=1 with w_mask=0 writes nothing.
- Register 0 is writable; unlike x0, it is not hard-wired to zero.
- Read, every cycle in RUN: vsN_data <= reg[vsN].
  - With BYPASS=1 and we=1, vd==vsN: the masked elements come from w_data and the others from the stored value.
  - With BYPASS=0: the pre-write value is returned.
- v0_data follows the same rule, with index fixed at 0.
- In INIT: all read outputs are held at 0 and we is ignored.
- Several read ports may address the same register; each port independently gets the identical value.

## Timing
- Reset values: ready=0, vs1_data=vs2_data=vs3_data=0, v0_data=0, state=INIT, clr_idx=0.
- Reset asserted at any time: outputs go to these values immediately (asynchronous). The sweep restarts from 0 after release.
- After rst_n rises, clr_idx is 0 at the first clock edge. ready rises after NREGS edges; the first write is accepted at edge NREGS+1.
- Read latency is 1 cycle: an index presented before edge N appears on the data output after edge N.
- Write-to-read:
  - BYPASS=1: a write at edge N is visible on a read of the same index sampled at edge N.
  - BYPASS=0: it is visible at edge N+1.
- There is no backpressure. Every RUN cycle accepts one write and three reads.

## Structure
- Shared package vrf_pkg: default VLEN, ELEN and NREGS localparams, the derived NELEM and AW, and the FSM state typedef (VRF_INIT, VRF_RUN).
- Sub-module vrf_read_port: registered read mux plus bypass merge. Instantiated four times (vs1, vs2, vs3, and a fixed-zero index for v0).
- Storage is a plain array with no reset, so it maps to distributed RAM or flops.

## Test plan
- Reset/init: release rst_n, then hold we=1.
  - ready must stay 0 for exactly 32 edges.
  - All reads must return 0, including a read of reg 31 immediately after ready=1.
  - No write may land during INIT.
- Masked write: write reg 5 = 0xFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF with mask 4'b1111, then 0x1111_2222_3333_4444_5555_6666_7777_8888 with mask 4'b0101. Reading vs1=5 must give 0xFFFF_FFFF_3333_4444_FFFF_FFFF_7777_8888.
- Bypass:
  - BYPASS=1: write reg 7 = pattern A (mask all ones) while vs2=7 in the same cycle. vs2_data must equal A on the next cycle.
  - BYPASS=0: the same stimulus returns the old value, then A one cycle later.
- v0 path: write reg 0 = 0x...0F (mask 4'b0001). v0_data must update with the same latency as vs3_data reading index 0, and the other elements must stay 0.
- Three-port conflict: vs1=vs2=vs3=9 with a concurrent write to 9. All three outputs must be identical every cycle.
- Mid-operation reset: assert rst_n low during a write burst.
  - ready and all outputs must go to 0 without a clock edge.
  - After release, previously written registers must read 0 once ready=1.
